// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite slave exposing NUM_REGS DATA_WIDTH-bit registers, with independent read/write channels.
// Define AXI4_LITE_REG_SLAVE_STRB_EN to add the WSTRB port and byte-lane write enables.
module axi4_lite_reg_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
`ifdef AXI4_LITE_REG_SLAVE_STRB_EN
  input  logic [DATA_WIDTH/8-1:0]        WSTRB,
`endif
  input  logic                           WVALID,
  output logic                           WREADY,
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(NUM_REGS * STRB_W);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  wstate_t               r_wstate;
  rstate_t               r_rstate;
  logic                  r_up;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]     r_wstrb;
  logic [1:0]            r_bresp;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  logic                  w_aw_hs, w_w_hs, w_ar_hs;
  logic [STRB_W-1:0]     w_strb;
  logic                  w_commit;
  logic [ADDR_WIDTH-1:0] w_cmt_addr;
  logic [DATA_WIDTH-1:0] w_cmt_data;
  logic [STRB_W-1:0]     w_cmt_strb;
  logic                  w_cmt_ok;
  logic [IDX_W-1:0]      w_cmt_idx;
  logic                  w_rd_ok;
  logic [IDX_W-1:0]      w_rd_idx;

`ifdef AXI4_LITE_REG_SLAVE_STRB_EN
  assign w_strb = WSTRB;
`else
  assign w_strb = '1;
`endif

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < ADDR_LIMIT;
  endfunction

  // r_up holds every ready low until the first clock edge after reset release.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_up <= 1'b0;
    else          r_up <= 1'b1;
  end

  assign AWREADY = r_up && (r_wstate == W_IDLE || r_wstate == W_HAVE_DATA);
  assign WREADY  = r_up && (r_wstate == W_IDLE || r_wstate == W_HAVE_ADDR);
  assign ARREADY = r_up && (r_rstate == R_IDLE);
  assign BVALID  = (r_wstate == W_RESP);
  assign BRESP   = BVALID ? r_bresp : RESP_OKAY;
  assign RVALID  = (r_rstate == R_DATA);
  assign RDATA   = r_rdata;
  assign RRESP   = r_rresp;

  assign w_aw_hs = AWVALID && AWREADY;
  assign w_w_hs  = WVALID && WREADY;
  assign w_ar_hs = ARVALID && ARREADY;

  // The commit takes whichever half arrives live this cycle and the latched copy of the other.
  always_comb begin
    w_commit   = 1'b0;
    w_cmt_addr = r_awaddr;
    w_cmt_data = r_wdata;
    w_cmt_strb = r_wstrb;
    case (r_wstate)
      W_IDLE: if (w_aw_hs && w_w_hs) begin
        w_commit   = 1'b1;
        w_cmt_addr = AWADDR;
        w_cmt_data = WDATA;
        w_cmt_strb = w_strb;
      end
      W_HAVE_ADDR: if (w_w_hs) begin
        w_commit   = 1'b1;
        w_cmt_data = WDATA;
        w_cmt_strb = w_strb;
      end
      W_HAVE_DATA: if (w_aw_hs) begin
        w_commit   = 1'b1;
        w_cmt_addr = AWADDR;
      end
      default: ;
    endcase
  end

  assign w_cmt_ok  = in_range(w_cmt_addr);
  assign w_cmt_idx = w_cmt_addr[LSB +: IDX_W];
  assign w_rd_ok   = in_range(ARADDR);
  assign w_rd_idx  = ARADDR[LSB +: IDX_W];

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_wstate <= W_IDLE;
      r_awaddr <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_bresp  <= RESP_OKAY;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_commit) begin
            r_wstate <= W_RESP;
          end else if (w_aw_hs) begin
            r_awaddr <= AWADDR;
            r_wstate <= W_HAVE_ADDR;
          end else if (w_w_hs) begin
            r_wdata  <= WDATA;
            r_wstrb  <= w_strb;
            r_wstate <= W_HAVE_DATA;
          end
        end
        W_HAVE_ADDR, W_HAVE_DATA: if (w_commit) r_wstate <= W_RESP;
        W_RESP: if (BREADY) r_wstate <= W_IDLE;
        default: r_wstate <= W_IDLE;
      endcase
      if (w_commit) r_bresp <= w_cmt_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_regs <= '{default: '0};
    end else if (w_commit && w_cmt_ok) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (w_cmt_strb[b]) r_regs[w_cmt_idx][b*8 +: 8] <= w_cmt_data[b*8 +: 8];
      end
    end
  end

  // Read data is sampled from r_regs before any same-edge write lands.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_rstate <= R_IDLE;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else begin
      case (r_rstate)
        R_IDLE: if (w_ar_hs) begin
          r_rdata  <= w_rd_ok ? r_regs[w_rd_idx] : '0;
          r_rresp  <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
          r_rstate <= R_DATA;
        end
        R_DATA: if (RREADY) begin
          r_rdata  <= '0;
          r_rresp  <= RESP_OKAY;
          r_rstate <= R_IDLE;
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_o
    assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
  end

endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// Directed bench for axi4_lite_reg_slave: reference register model plus B/R response scoreboards.
// Builds with or without AXI4_LITE_REG_SLAVE_STRB_EN.
module tb_axi4_lite_reg_slave;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 16;
  localparam int RW = NR * DW;

  logic          ACLK = 1'b0;
  logic          ARESETN;
  logic [AW-1:0] AWADDR, ARADDR;
  logic          AWVALID, WVALID, BREADY, ARVALID, RREADY;
  logic          AWREADY, WREADY, BVALID, ARREADY, RVALID;
  logic [DW-1:0] WDATA, RDATA;
  logic [1:0]    BRESP, RRESP;
  logic [RW-1:0] regs_o;
`ifdef AXI4_LITE_REG_SLAVE_STRB_EN
  logic [DW/8-1:0] WSTRB;
`endif

  always #5 ACLK = ~ACLK;

  axi4_lite_reg_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA),
`ifdef AXI4_LITE_REG_SLAVE_STRB_EN
    .WSTRB(WSTRB),
`endif
    .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .regs_o(regs_o)
  );

  typedef struct packed {logic [DW-1:0] data; logic [1:0] resp;} rexp_t;

  int            n_total = 0;
  int            n_bad   = 0;
  logic [DW-1:0] mdl [NR];
  logic [1:0]    q_b [$];
  rexp_t         q_r [$];
  logic [1:0]    mon_b;
  rexp_t         mon_r;

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  function automatic logic rdy(input int w);
    case (w)
      0:       return AWREADY;
      1:       return WREADY;
      default: return ARREADY;
    endcase
  endfunction

  task automatic wait_rdy(input int w, input string tag);
    int n = 0;
    while (!rdy(w) && n < 20) begin
      step();
      n++;
    end
    if (!rdy(w)) chk({tag, "_timeout"}, 0, 1);
  endtask

  function automatic logic in_rng(input logic [AW-1:0] a);
    return a < AW'(NR * DW / 8);
  endfunction

  function automatic logic [RW-1:0] model_vec();
    logic [RW-1:0] v;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = mdl[i];
    return v;
  endfunction

  function automatic void model_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                      input logic [DW/8-1:0] s);
    if (in_rng(a))
      for (int b = 0; b < DW / 8; b++)
        if (s[b]) mdl[a[5:2]][b*8 +: 8] = d[b*8 +: 8];
  endfunction

  // w_lead: cycles by which the W handshake precedes AW (0 = same edge).
  task automatic write_tx(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [DW/8-1:0] s, input int w_lead);
    logic [DW/8-1:0] eff;
`ifdef AXI4_LITE_REG_SLAVE_STRB_EN
    eff = s;
`else
    eff = '1;
`endif
    q_b.push_back(in_rng(a) ? 2'b00 : 2'b10);
    step();
    WDATA = d;
    WVALID = 1'b1;
`ifdef AXI4_LITE_REG_SLAVE_STRB_EN
    WSTRB = s;
`endif
    if (w_lead == 0) begin
      AWADDR = a;
      AWVALID = 1'b1;
      wait_rdy(0, "awready");
    end
    wait_rdy(1, "wready");
    step();
    WVALID = 1'b0;
    AWVALID = 1'b0;
    if (w_lead > 0) begin
      for (int i = 1; i < w_lead; i++) begin
        @(negedge ACLK);
        chk("no_early_commit", regs_o, model_vec());
        chk("no_early_bvalid", BVALID, 0);
        step();
      end
      AWADDR = a;
      AWVALID = 1'b1;
      wait_rdy(0, "awready_late");
      step();
      AWVALID = 1'b0;
    end
    model_write(a, d, eff);
    @(negedge ACLK);
    chk("bvalid_latency", BVALID, 1);
    chk("awready_in_resp", AWREADY, 0);
    chk("regs_o_after_write", regs_o, model_vec());
  endtask

  task automatic read_tx(input logic [AW-1:0] a);
    q_r.push_back({in_rng(a) ? mdl[a[5:2]] : '0, in_rng(a) ? 2'b00 : 2'b10});
    step();
    ARADDR = a;
    ARVALID = 1'b1;
    wait_rdy(2, "arready");
    step();
    ARVALID = 1'b0;
    @(negedge ACLK);
    chk("rvalid_latency", RVALID, 1);
  endtask

  // Scoreboard: a response is consumed on the cycle its handshake completes.
  always @(negedge ACLK) begin
    if (ARESETN === 1'b1) begin
      if (BVALID && BREADY) begin
        chk("b_expected", q_b.size() != 0, 1);
        if (q_b.size() != 0) begin
          mon_b = q_b.pop_front();
          chk("bresp", BRESP, mon_b);
        end
      end
      if (RVALID && RREADY) begin
        chk("r_expected", q_r.size() != 0, 1);
        if (q_r.size() != 0) begin
          mon_r = q_r.pop_front();
          chk("rdata", RDATA, mon_r.data);
          chk("rresp", RRESP, mon_r.resp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end of the sequence");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ARESETN = 1'b1;
    AWADDR = '0; ARADDR = '0; WDATA = '0;
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    BREADY = 1'b1; RREADY = 1'b1;
`ifdef AXI4_LITE_REG_SLAVE_STRB_EN
    WSTRB = '1;
`endif
    for (int i = 0; i < NR; i++) mdl[i] = '0;
    #1 ARESETN = 1'b0;

    // Reset state
    #11;
    chk("rst_awready", AWREADY, 0);
    chk("rst_wready", WREADY, 0);
    chk("rst_arready", ARREADY, 0);
    chk("rst_bvalid", BVALID, 0);
    chk("rst_rvalid", RVALID, 0);
    chk("rst_rdata", RDATA, 0);
    chk("rst_regs", regs_o, 0);
    repeat (2) step();
    ARESETN = 1'b1;
    #1 chk("ready_before_edge", {AWREADY, WREADY, ARREADY}, 3'b000);
    step();
    @(negedge ACLK);
    chk("ready_after_edge", {AWREADY, WREADY, ARREADY}, 3'b111);

    // Same-cycle AW/W write then read-back
    write_tx(32'h04, 32'hDEADBEEF, 4'hF, 0);
    chk("deadbeef_reg1", regs_o[1*DW +: DW], 32'hDEADBEEF);
    read_tx(32'h04);
    step();
    @(negedge ACLK);
    chk("idle_outputs", {RVALID, BVALID, RDATA, RRESP, BRESP}, 0);

    // W three cycles before AW
    write_tx(32'h08, 32'h12345678, 4'hF, 3);
    read_tx(32'h08);

    // Out-of-range and boundary addresses
    write_tx(32'h40, 32'hCAFEF00D, 4'hF, 0);
    read_tx(32'h40);
    write_tx(32'h1000_0004, 32'h55555555, 4'hF, 0);
    read_tx(32'h3C);
    write_tx(32'h3C, 32'hA5A5C3C3, 4'hF, 0);
    read_tx(32'h3F);
    read_tx(32'h1000_003C);

    // Back-pressure on both response channels
    step();
    BREADY = 1'b0;
    RREADY = 1'b0;
    write_tx(32'h10, 32'h0BADF00D, 4'hF, 0);
    read_tx(32'h10);
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      chk("hold_b", {BVALID, BRESP}, 3'b100);
      chk("hold_r", {RVALID, RRESP, RDATA}, {1'b1, 2'b00, 32'h0BADF00D});
      chk("hold_readies", {AWREADY, WREADY, ARREADY}, 3'b000);
      step();
    end
    BREADY = 1'b1;
    RREADY = 1'b1;
    step();
    @(negedge ACLK);
    chk("hold_release", {BVALID, RVALID}, 2'b00);

    // Write commit and read of the same register on one edge
    q_b.push_back(2'b00);
    q_r.push_back({mdl[3], 2'b00});
    step();
    AWADDR = 32'h0C; WDATA = 32'h11112222; ARADDR = 32'h0C;
`ifdef AXI4_LITE_REG_SLAVE_STRB_EN
    WSTRB = '1;
`endif
    AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
    chk("coincident_readies", {AWREADY, WREADY, ARREADY}, 3'b111);
    step();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    model_write(32'h0C, 32'h11112222, '1);
    @(negedge ACLK);
    chk("coincident_valids", {BVALID, RVALID}, 2'b11);
    chk("coincident_regs", regs_o, model_vec());
    read_tx(32'h0C);

    // Byte strobes
    write_tx(32'h08, 32'hFFFFFFFF, 4'hF, 0);
    write_tx(32'h08, 32'h00000000, 4'b0101, 0);
`ifdef AXI4_LITE_REG_SLAVE_STRB_EN
    chk("strb_0101", regs_o[2*DW +: DW], 32'hFF00FF00);
    read_tx(32'h08);
    write_tx(32'h08, 32'h12345678, 4'b0000, 0);
    chk("strb_none", regs_o[2*DW +: DW], 32'hFF00FF00);
`else
    chk("strb_ignored", regs_o[2*DW +: DW], 32'h00000000);
`endif
    read_tx(32'h08);

    // Reset while an address is latched
    step();
    AWADDR = 32'h0C;
    AWVALID = 1'b1;
    wait_rdy(0, "awready_pre_reset");
    step();
    AWVALID = 1'b0;
    chk("pre_reset_have_addr", {AWREADY, WREADY}, 2'b01);
    #2 ARESETN = 1'b0;
    #1;
    chk("async_readies", {AWREADY, WREADY, ARREADY}, 3'b000);
    chk("async_valids", {BVALID, RVALID}, 2'b00);
    chk("async_resp_data", {BRESP, RRESP, RDATA}, 0);
    chk("async_regs", regs_o, 0);
    for (int i = 0; i < NR; i++) mdl[i] = '0;
    repeat (2) step();
    ARESETN = 1'b1;
    #1 chk("ready_before_edge2", {AWREADY, WREADY, ARREADY}, 3'b000);
    step();
    @(negedge ACLK);
    chk("ready_after_edge2", {AWREADY, WREADY, ARREADY}, 3'b111);
    read_tx(32'h0C);
    step();
    @(negedge ACLK);
    chk("post_reset_regs", regs_o, 0);
    chk("queues_drained", q_b.size() + q_r.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/axi4_lite_reg_slave.md
AXI4_LITE_REG_SLAVE -- requirements
Module: axi4_lite_reg_slave

Interface
REQ-001 The block SHALL use a single clock, ACLK, and an asynchronous active-low reset, ARESETN.
REQ-002 Parameter ADDR_WIDTH, default 32: address bus width in bits.
REQ-003 Parameter DATA_WIDTH, default 32 (legal values 32 or 64): data bus width in bits.
REQ-004 Parameter NUM_REGS, default 16 (power of 2, from 2 to 256): number of DATA_WIDTH-bit registers.
REQ-005 Ports, in this order (name, direction, width, meaning):
- ACLK, in, 1, clock.
- ARESETN, in, 1, asynchronous active-low reset.
- AWADDR, in, ADDR_WIDTH, write address.
- AWVALID, in, 1, write address valid.
- AWREADY, out, 1, write address ready.
- WDATA, in, DATA_WIDTH, write data.
- WSTRB, in, DATA_WIDTH/8, byte strobes; present only under REQ-030.
- WVALID, in, 1, write data valid.
- WREADY, out, 1, write data ready.
- BRESP, out, 2, write response.
- BVALID, out, 1, write response valid.
- BREADY, in, 1, write response ready.
- ARADDR, in, ADDR_WIDTH, read address.
- ARVALID, in, 1, read address valid.
- ARREADY, out, 1, read address ready.
- RDATA, out, DATA_WIDTH, read data.
- RRESP, out, 2, read response.
- RVALID, out, 1, read data valid.
- RREADY, in, 1, read data ready.
- regs_o, out, NUM_REGS*DATA_WIDTH, flattened register contents; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].

Function
REQ-006 Address decode SHALL work as follows:
- LSB = log2(DATA_WIDTH/8); register index = addr[LSB +: log2(NUM_REGS)].
- addr bits below LSB are ignored.
- Any address at or above NUM_REGS*(DATA_WIDTH/8) is out of range.
REQ-007 Response codes SHALL be OKAY = 2'b00 for in-range addresses and SLVERR = 2'b10 for out-of-range addresses.
REQ-008 The write FSM SHALL have four states: W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP.
REQ-009 AWREADY SHALL be 1 only in W_IDLE and W_HAVE_DATA; WREADY SHALL be 1 only in W_IDLE and W_HAVE_ADDR.
REQ-010 An AW handshake in W_IDLE SHALL latch AWADDR and move to W_HAVE_ADDR; a W handshake in W_IDLE SHALL latch WDATA/WSTRB and move to W_HAVE_DATA.
REQ-011 When both AW and W handshakes complete (in the same cycle or in different cycles), the register write SHALL commit at that clock edge, and BVALID/BRESP SHALL be valid from the next cycle; the FSM SHALL enter W_RESP.
REQ-012 An out-of-range write SHALL leave all registers unchanged and return BRESP = SLVERR.
REQ-013 In W_RESP, BVALID and BRESP SHALL hold until BREADY = 1, after which the FSM SHALL return to W_IDLE, with AWREADY/WREADY high in the next cycle.
REQ-014 The read FSM SHALL have two states: R_IDLE (ARREADY = 1) and R_DATA (RVALID = 1, ARREADY = 0).
REQ-015 An AR handshake SHALL capture RDATA/RRESP at that edge, so RVALID is 1 in the following cycle (1-cycle latency).
REQ-016 RDATA and RRESP SHALL hold stable while RVALID = 1 and RREADY = 0.
REQ-017 An out-of-range read SHALL return RDATA = 0 and RRESP = SLVERR.
REQ-018 The read and write paths SHALL be fully independent and concurrent.
REQ-019 If a write commit and an AR handshake to the same register occur on the same edge, RDATA SHALL be the pre-write value.
REQ-020 regs_o SHALL reflect committed register values with no added latency.
REQ-021 When neither RVALID nor BVALID is set, RDATA SHALL be 0 and BRESP/RRESP SHALL be OKAY.

Reset
REQ-022 While ARESETN = 0, the block SHALL immediately, without waiting for a clock edge:
- clear all registers to 0;
- drive BVALID = RVALID = 0, AWREADY = WREADY = ARREADY = 0, RDATA = 0, BRESP = RRESP = 2'b00;
- put the write FSM in W_IDLE and the read FSM in R_IDLE.
REQ-023 AWREADY, WREADY and ARREADY SHALL rise at the first ACLK edge after ARESETN deasserts.
REQ-024 A reset mid-transaction SHALL discard any latched address/data and any pending response; no partial write SHALL occur.

Configuration
REQ-030 Macro AXI4_LITE_REG_SLAVE_STRB_EN SHALL control byte strobes:
- Defined: port WSTRB exists, and a write updates only the byte lanes whose strobe bit is 1; WSTRB = 0 completes the handshake with BRESP = OKAY and no change.
- Undefined: no WSTRB port, and every write updates the full word.

Verification
REQ-040 Reset, then write 32'hDEADBEEF to 0x04 with AW and W in the same cycle, BREADY = 1 -> BVALID one cycle later with BRESP = 00; a read of 0x04 returns RDATA = DEADBEEF with RVALID one cycle after the AR handshake.
REQ-041 W handshake 3 cycles before AW -> no commit until AW; BVALID the cycle after AW; regs_o reflects the new value at the same time.
REQ-042 Write and read address 0x40 with NUM_REGS = 16 -> BRESP = 10, RRESP = 10, RDATA = 0; regs_o unchanged.
REQ-043 Hold BREADY/RREADY = 0 for 5 cycles -> BVALID/RVALID, BRESP, RDATA stable; AWREADY = WREADY = ARREADY = 0 throughout.
REQ-044 With STRB_EN defined, reg 0x08 = FFFFFFFF, write 0 with WSTRB = 4'b0101 -> reads FF00FF00. Without STRB_EN -> reads 00000000.
REQ-045 Assert ARESETN low while in W_HAVE_ADDR after writing 0x0C -> all outputs 0 asynchronously; a later read of 0x0C returns 0.
